// File: rtl/adder_pkg.sv
// Shared types and helpers for the registered adder.
// Optional parity output is built only when ADDER_PARITY_EN is defined.
package adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  // Widest operand the helpers handle; callers zero-extend into it and truncate back.
  localparam int unsigned MAX_WIDTH     = 32;

  typedef logic [DEFAULT_WIDTH:0] sum_t;

  // Zero-extended sum; the extra MSB carries out so the add never overflows.
  function automatic logic [MAX_WIDTH:0] add_ext(input logic [MAX_WIDTH-1:0] op_a,
                                                 input logic [MAX_WIDTH-1:0] op_b);
    return {1'b0, op_a} + {1'b0, op_b};
  endfunction

  // Parity bit that gives {value, bit} an even number of ones; zero-extension is harmless.
  function automatic logic even_par(input logic [MAX_WIDTH:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/adder_out_reg.sv
// Output stage of the adder: holds the result, applies hold/drain/replace rules and
// produces in_ready. The parity register exists only when ADDER_PARITY_EN is defined.
module adder_out_reg
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           in_valid_i,
  input  logic           out_ready_i,
  input  logic [WIDTH:0] sum_i,
`ifdef ADDER_PARITY_EN
  input  logic           par_i,
  output logic           c_par_o,
`endif
  output logic           in_ready_o,
  output logic [WIDTH:0] c_o,
  output logic           out_valid_o
);

  logic [WIDTH:0] c_d, c_q;
  logic           valid_d, valid_q;
  logic           accept;
`ifdef ADDER_PARITY_EN
  logic           par_d, par_q;
`endif

  // Next-state: a new sum replaces c on accept; otherwise a consume just drops valid.
  always_comb begin
    in_ready_o = !valid_q || out_ready_i;
    accept     = in_valid_i && in_ready_o;
    c_d        = c_q;
    valid_d    = valid_q;
`ifdef ADDER_PARITY_EN
    par_d      = par_q;
`endif
    if (accept) begin
      c_d     = sum_i;
      valid_d = 1'b1;
`ifdef ADDER_PARITY_EN
      par_d   = par_i;
`endif
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Result registers; async reset discards any pending result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_q     <= '0;
      valid_q <= 1'b0;
`ifdef ADDER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      c_q     <= c_d;
      valid_q <= valid_d;
`ifdef ADDER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign c_o         = c_q;
  assign out_valid_o = valid_q;
`ifdef ADDER_PARITY_EN
  assign c_par_o     = par_q;
`endif

endmodule

// File: rtl/adder_core.sv
// Registered unsigned adder with valid/ready handshake and a consumed-result counter.
// Define ADDER_PARITY_EN to add the registered even-parity output c_par.
module adder_core
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] txn_cnt
`ifdef ADDER_PARITY_EN
  ,
  output logic             c_par
`endif
);

  logic [WIDTH:0]   sum;
  logic [CNT_W-1:0] txn_cnt_d, txn_cnt_q;
`ifdef ADDER_PARITY_EN
  logic             sum_par;
`endif

  // Combinational sum, carry in the MSB.
  always_comb begin
    sum = (WIDTH + 1)'(add_ext(MAX_WIDTH'(a), MAX_WIDTH'(b)));
`ifdef ADDER_PARITY_EN
    sum_par = even_par(MAX_WIDTH'(sum));
`endif
  end

  adder_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .out_ready_i(out_ready),
    .sum_i      (sum),
`ifdef ADDER_PARITY_EN
    .par_i      (sum_par),
    .c_par_o    (c_par),
`endif
    .in_ready_o (in_ready),
    .c_o        (c),
    .out_valid_o(out_valid)
  );

  // Count results taken by downstream; wraps naturally.
  always_comb begin
    txn_cnt_d = txn_cnt_q;
    if (out_valid && out_ready) begin
      txn_cnt_d = txn_cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt_q <= '0;
    end else begin
      txn_cnt_q <= txn_cnt_d;
    end
  end

  assign txn_cnt = txn_cnt_q;

endmodule

// File: tb/tb_adder_core.sv
// Directed bench for adder_core (WIDTH=4, CNT_W=16). Parity checks appear when
// ADDER_PARITY_EN is defined.
module tb_adder_core;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   c;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] txn_cnt;
`ifdef ADDER_PARITY_EN
  logic             c_par;
`endif

  int n_tests;
  int n_fail;

  adder_core #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .c        (c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .txn_cnt  (txn_cnt)
`ifdef ADDER_PARITY_EN
    ,
    .c_par    (c_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic rdy);
    in_valid  = v;
    a         = av;
    b         = bv;
    out_ready = rdy;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(1'b0, 'x, 'x, 1'b0);

    // Reset then idle
    repeat (3) step();
    check_eq("rst_c", 32'(c), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_cnt", 32'(txn_cnt), 32'd0);
`ifdef ADDER_PARITY_EN
    check_eq("rst_par", 32'(c_par), 32'd0);
`endif
    rst_n = 1'b1;
    step();
    check_eq("idle_valid", 32'(out_valid), 32'd0);

    // Basic add 3+5
    drive(1'b1, 4'd3, 4'd5, 1'b1);
    step();
    check_eq("basic_c", 32'(c), 32'd8);
    check_eq("basic_valid", 32'(out_valid), 32'd1);
    check_eq("basic_cnt0", 32'(txn_cnt), 32'd0);
    drive(1'b0, 'x, 'x, 1'b1);
    step();
    check_eq("basic_cnt1", 32'(txn_cnt), 32'd1);
    check_eq("drain_valid", 32'(out_valid), 32'd0);
    check_eq("drain_keep_c", 32'(c), 32'd8);

    // Carry boundary, then zero operands back-to-back
    drive(1'b1, 4'd15, 4'd15, 1'b1);
    step();
    check_eq("max_c", 32'(c), 32'd30);
    check_eq("max_valid", 32'(out_valid), 32'd1);
`ifdef ADDER_PARITY_EN
    check_eq("max_par", 32'(c_par), 32'd0);
`endif
    drive(1'b1, 4'd0, 4'd0, 1'b1);
    step();
    check_eq("zero_c", 32'(c), 32'd0);
    check_eq("zero_valid", 32'(out_valid), 32'd1);
    check_eq("zero_cnt", 32'(txn_cnt), 32'd2);
`ifdef ADDER_PARITY_EN
    check_eq("zero_par", 32'(c_par), 32'd0);
`endif
    drive(1'b1, 4'd1, 4'd2, 1'b1);
    step();
    check_eq("three_c", 32'(c), 32'd3);
`ifdef ADDER_PARITY_EN
    check_eq("three_par", 32'(c_par), 32'd0);
`endif
    drive(1'b1, 4'd1, 4'd0, 1'b1);
    step();
    check_eq("one_c", 32'(c), 32'd1);
`ifdef ADDER_PARITY_EN
    check_eq("one_par", 32'(c_par), 32'd1);
`endif
    drive(1'b0, 'x, 'x, 1'b1);
    step();
    check_eq("carry_cnt", 32'(txn_cnt), 32'd5);
    check_eq("carry_drain", 32'(out_valid), 32'd0);

    // Backpressure: 8 pending, 1+1 offered while out_ready is low
    drive(1'b1, 4'd3, 4'd5, 1'b0);
    step();
    check_eq("bp_c0", 32'(c), 32'd8);
    check_eq("bp_ready0", 32'(in_ready), 32'd0);
    drive(1'b1, 4'd1, 4'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("bp_hold_c", 32'(c), 32'd8);
      check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
      check_eq("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    check_eq("bp_cnt", 32'(txn_cnt), 32'd5);
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    check_eq("bp_new_c", 32'(c), 32'd2);
    check_eq("bp_new_valid", 32'(out_valid), 32'd1);
    check_eq("bp_cnt_consumed", 32'(txn_cnt), 32'd6);
    drive(1'b0, 'x, 'x, 1'b1);
    step();
    check_eq("bp_drain_valid", 32'(out_valid), 32'd0);
    check_eq("bp_drain_cnt", 32'(txn_cnt), 32'd7);

    // Streaming (i, 15-i), one result per cycle
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, WIDTH'(i), WIDTH'(15 - i), 1'b1);
      step();
      check_eq("stream_c", 32'(c), 32'd15);
      check_eq("stream_valid", 32'(out_valid), 32'd1);
      check_eq("stream_cnt", 32'(txn_cnt), 32'(7 + i));
    end
    drive(1'b0, 'x, 'x, 1'b1);
    step();
    check_eq("stream_end_valid", 32'(out_valid), 32'd0);
    check_eq("stream_end_cnt", 32'(txn_cnt), 32'd23);

    // Reset mid-operation with a pending result
    drive(1'b1, 4'd15, 4'd15, 1'b0);
    step();
    check_eq("pre_rst_c", 32'(c), 32'd30);
    drive(1'b0, 'x, 'x, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_c", 32'(c), 32'd0);
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_cnt", 32'(txn_cnt), 32'd0);
    check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    drive(1'b0, 'x, 'x, 1'b1);
    step();
    check_eq("post_rst_valid", 32'(out_valid), 32'd0);
    check_eq("post_rst_cnt", 32'(txn_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
